sram22_req_adapter: RTL and testbench

//   Valid/ready front-end that drives an sram22 single-port macro (e.g. 512x32, 8-bit write mask).

---
 rtl/sram22_req_adapter_if.sv | 33 +++
 rtl/sram22_req_adapter.sv | 115 +++++++++++
 tb/tb_sram22_req_adapter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram22_req_adapter_if.sv
// Bundle of request, response and macro-pin signals for sram22_req_adapter.
// The adapter takes the slave modport; the requester/consumer/macro side takes master.
// Parameters must match the adapter instance and the sram22 macro geometry.
interface sram22_req_adapter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [WMASK_WIDTH-1:0] req_wmask;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_WIDTH-1:0]  rsp_rdata;
  logic                   sram_we;
  logic [WMASK_WIDTH-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0]  sram_addr;
  logic [DATA_WIDTH-1:0]  sram_din;
  logic [DATA_WIDTH-1:0]  sram_dout;

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready, sram_dout,
    output req_ready, rsp_valid, rsp_rdata, sram_we, sram_wmask, sram_addr, sram_din
  );

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready, sram_dout,
    input  req_ready, rsp_valid, rsp_rdata, sram_we, sram_wmask, sram_addr, sram_din
  );
endinterface

// File: rtl/sram22_req_adapter.sv
// Valid/ready front-end driving sram22 single-port macro pins, with a 2-entry read FIFO.
// Latency: read fire at edge N -> dout captured and rsp_valid at edge N+1 (2 edges).
// Backpressure: req_ready = (pending + fifo count - pop) < 2; rsp_ready frees a credit combinationally.
// Optional feature macro: SRAM_ADAPTER_WRITE_ACK_EN (writes take a credit and return rsp_rdata=0).
module sram22_req_adapter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 4
) (
  input logic               clk,
  input logic               rstb,
  sram22_req_adapter_if.slave bus
);

  logic                   fire;
  logic                   pop;
  logic                   push;
  logic                   pend_set;
  logic [2:0]             occ;
  logic [WMASK_WIDTH-1:0] wmask_w;
  logic [DATA_WIDTH-1:0]  push_dat;

  logic                   rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [1:0]             count_q, count_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]  fifo_q [2];
  logic [DATA_WIDTH-1:0]  fifo_d [2];
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
  logic                   pend_wr_q, pend_wr_d;
`endif

  // Credit accounting: one outstanding macro read plus FIFO entries may never exceed 2.
  // Holding reset forces req_ready low so nothing fires into a macro we are not tracking.
  assign pop           = (count_q != 2'd0) & bus.rsp_ready;
  assign occ           = {2'b00, rd_pend_q} + {1'b0, count_q} - {2'b00, pop};
  assign bus.req_ready = rstb & (occ < 3'd2);
  assign fire          = bus.req_valid & bus.req_ready;

  // Macro pins: idle cycles re-read the last fired address with we=0, result ignored.
  assign wmask_w        = (fire & bus.req_we) ? bus.req_wmask : '0;
  assign bus.sram_we    = fire & bus.req_we;
  assign bus.sram_wmask = wmask_w;
  assign bus.sram_addr  = fire ? bus.req_addr : addr_q;
  assign bus.sram_din   = bus.req_wdata;

  // The macro presents dout one edge after it sampled the read, so push lags fire by one edge.
  assign push = rd_pend_q;
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
  assign pend_set = fire;
  assign push_dat = pend_wr_q ? '0 : bus.sram_dout;
`else
  assign pend_set = fire & ~bus.req_we;
  assign push_dat = bus.sram_dout;
`endif

  assign bus.rsp_valid = (count_q != 2'd0);
  assign bus.rsp_rdata = fifo_q[rd_ptr_q];

  // Next-state for pending slot, address hold register and FIFO pointers/storage.
  always_comb begin
    rd_pend_d = pend_set;
    addr_d    = fire ? bus.req_addr : addr_q;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    fifo_d    = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_dat;
    end
  end

`ifdef SRAM_ADAPTER_WRITE_ACK_EN
  // Remember whether the pending slot belongs to a write so its response carries zero.
  always_comb begin
    pend_wr_d = fire & bus.req_we;
  end

  // Write-ack tag register; cleared with the pending slot on reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pend_wr_q <= 1'b0;
    end else begin
      pend_wr_q <= pend_wr_d;
    end
  end
`endif

  // State registers; reset drops any read in flight so it never produces a response.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
    end
  end

  // The credit rule guarantees a push never lands in a full FIFO without a matching pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstb)
    !(push && (count_q == 2'd2) && !pop));

endmodule

// File: tb/tb_sram22_req_adapter.sv
// Randomized + directed scoreboard bench for sram22_req_adapter with a behavioural macro.
// Reference model: word array + outstanding-credit count; expected read data queued at fire.
// Monitor pops the queue on every rsp handshake; a separate observer checks pins and req_ready.
module tb_sram22_req_adapter;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  sram22_req_adapter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus ();

  sram22_req_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural sram22 macro: samples pins at the rising edge, dout registered.
  logic [DW-1:0] macro_mem [512];
  initial begin : macro_model
    logic [DW-1:0] w;
    forever begin
      @(posedge clk);
      if (bus.sram_we) begin
        w = macro_mem[bus.sram_addr];
        for (int b = 0; b < MW; b++)
          if (bus.sram_wmask[b]) w[b*8 +: 8] = bus.sram_din[b*8 +: 8];
        macro_mem[bus.sram_addr] <= w;
      end
      bus.sram_dout <= macro_mem[bus.sram_addr];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] exp_q [$];
  int            used = 0;
  int            fire_cnt = 0;
  logic [AW-1:0] last_addr = '0;

  // Observer: checks req_ready against the credit count and the macro pins, updates the model.
  initial begin : observer
    bit            pop_now, fire_now, exp_rdy, exp_we;
    logic [MW-1:0] exp_mask;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] bm;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        used = 0;
        last_addr = '0;
        exp_q.delete();
      end
      pop_now  = rstb && bus.rsp_valid && bus.rsp_ready;
      exp_rdy  = rstb && ((used - int'(pop_now)) < 2);
      check(bus.req_ready == exp_rdy, "req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      fire_now = bus.req_valid && exp_rdy;
      exp_we   = fire_now && bus.req_we;
      exp_mask = exp_we ? bus.req_wmask : '0;
      exp_addr = fire_now ? bus.req_addr : last_addr;
      check({bus.sram_we, bus.sram_wmask, bus.sram_addr} == {exp_we, exp_mask, exp_addr}
            && bus.sram_din == bus.req_wdata, "sram_pins",
            64'({bus.sram_we, bus.sram_wmask, bus.sram_addr}), 64'({exp_we, exp_mask, exp_addr}));
      if (fire_now) begin
        fire_cnt++;
        last_addr = bus.req_addr;
        if (bus.req_we) begin
          bm = {{8{bus.req_wmask[3]}}, {8{bus.req_wmask[2]}},
                {8{bus.req_wmask[1]}}, {8{bus.req_wmask[0]}}};
          ref_mem[bus.req_addr] = (ref_mem[bus.req_addr] & ~bm) | (bus.req_wdata & bm);
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
          exp_q.push_back('0);
          used++;
`endif
        end else begin
          exp_q.push_back(ref_mem[bus.req_addr]);
          used++;
        end
      end
      if (pop_now) used--;
    end
  end

  // Monitor: compares every response handshake with the scoreboard head; checks hold stability.
  initial begin : monitor
    bit            hold_pend = 0;
    logic [DW-1:0] hold_dat = '0;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        hold_pend = 0;
      end else begin
        if (hold_pend)
          check(bus.rsp_valid && bus.rsp_rdata == hold_dat, "rsp_stable",
                64'(bus.rsp_rdata), 64'(hold_dat));
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_rsp", 64'(bus.rsp_rdata), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check(bus.rsp_rdata == e, "rsp_data", 64'(bus.rsp_rdata), 64'(e));
          end
        end
        hold_pend = bus.rsp_valid && !bus.rsp_ready;
        hold_dat  = bus.rsp_rdata;
      end
    end
  end

  // Issue one request and hold it until accepted; returns at fire edge + 1.
  task automatic do_req(input logic we, input logic [MW-1:0] m, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int stalls);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_wmask = m;
    bus.req_addr  = a;
    bus.req_wdata = d;
    stalls = 0;
    @(negedge clk);
    while (!bus.req_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!bus.req_ready) check(1'b0, "req_timeout", 64'(stalls), 64'(50));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Read with an empty response FIFO and rsp_ready=1: checks the 2-edge latency and data.
  task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int st;
    do_req(1'b0, '0, a, '0, st);
    check(bus.rsp_valid == 1'b0, "rd_lat_early", 64'(bus.rsp_valid), 64'(0));
    @(posedge clk);
    #1;
    check(bus.rsp_valid == 1'b1, "rd_lat_valid", 64'(bus.rsp_valid), 64'(1));
    check(bus.rsp_rdata == exp, "rd_data", 64'(bus.rsp_rdata), 64'(exp));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int            st, stalls, fc0, k;
    bit            f, fired, any_vld;
    logic [AW-1:0] bp_addr [3];
    logic [DW-1:0] v;

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_wmask = 4'hF;
    bus.req_addr  = 9'h003;
    bus.req_wdata = $urandom;
    bus.rsp_ready = 1'b1;

    // Reset held with a pending write request.
    repeat (3) @(posedge clk);
    #1;
    check(bus.req_ready == 1'b0, "rst_req_ready", 64'(bus.req_ready), 64'(0));
    check(bus.sram_we == 1'b0, "rst_sram_we", 64'(bus.sram_we), 64'(0));
    check(bus.rsp_valid == 1'b0, "rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check(bus.rsp_rdata == '0, "rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    bus.req_valid = 1'b0;
    #2 rstb = 1'b1;
    @(posedge clk);
    #1;

    // Known contents for every address the bench reads.
    for (int a = 0; a < 32; a++) do_req(1'b1, 4'hF, 9'(a), $urandom, st);

    // Full, partial and empty-mask writes on one word.
    do_req(1'b1, 4'hF, 9'h005, 32'hDEADBEEF, st);
    read_check(9'h005, 32'hDEADBEEF);
    do_req(1'b1, 4'b0010, 9'h005, 32'h0000AB00, st);
    read_check(9'h005, 32'hDEADABEF);
    do_req(1'b1, 4'h0, 9'h005, 32'h12345678, st);
    read_check(9'h005, 32'hDEADABEF);

    // Read immediately after write to the same address.
    v = $urandom;
    do_req(1'b1, 4'hF, 9'h010, v, st);
    read_check(9'h010, v);

    // Streaming reads with rsp_ready held high.
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, '0, 9'(i), '0, st);
      stalls += st;
    end
    check(stalls == 0, "stream_no_stall", 64'(stalls), 64'(0));
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: three reads with rsp_ready low, then a one-cycle rsp_ready pulse.
    bp_addr[0] = 9'h007;
    bp_addr[1] = 9'h008;
    bp_addr[2] = 9'h009;
    bus.rsp_ready = 1'b0;
    fc0 = fire_cnt;
    k = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = bp_addr[0];
    repeat (6) begin
      @(negedge clk);
      f = bus.req_ready;
      @(posedge clk);
      #1;
      if (f) begin
        k++;
        if (k < 3) bus.req_addr = bp_addr[k];
        else bus.req_valid = 1'b0;
      end
    end
    check((fire_cnt - fc0) == 2, "bp_accepted", 64'(fire_cnt - fc0), 64'(2));
    check(bus.req_ready == 1'b0, "bp_ready_low", 64'(bus.req_ready), 64'(0));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check(bus.req_ready == 1'b1, "bp_pulse_ready", 64'(bus.req_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check((fire_cnt - fc0) == 3, "bp_third_fire", 64'(fire_cnt - fc0), 64'(3));
    repeat (3) @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic with random response backpressure.
    fired = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) fired = 1;
      @(posedge clk);
      #1;
      if (!bus.req_valid || fired) begin
        fired = 0;
        bus.req_valid = ($urandom_range(0, 3) != 0);
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_wmask = 4'($urandom_range(0, 15));
        bus.req_addr  = 9'($urandom_range(0, 31));
        bus.req_wdata = $urandom;
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(exp_q.size() == 0, "drain_empty", 64'(exp_q.size()), 64'(0));

    // Async reset the cycle after a read fire: that read must never respond.
    do_req(1'b0, '0, 9'h00C, '0, st);
    #2 rstb = 1'b0;
    repeat (2) @(posedge clk);
    #3 rstb = 1'b1;
    any_vld = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) any_vld = 1;
    end
    check(any_vld == 0, "rst_inflight_dropped", 64'(any_vld), 64'(0));
    check(exp_q.size() == 0, "final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
